// File: rtl/snax_simbacore_ctrl_shell.sv
// Control shell between the SNAX CSR manager and the SimbaCore config port.
// It latches a CSR job, launches it over a valid/ready config handshake, and
// counts output-stream beats to decide when the job has finished. Busy state,
// run cycles, total beats and per-channel beats are exposed as RO CSRs.
// Optional feature: define SNAX_SIMBACORE_CFG_QUEUE_EN to add a one-deep shadow
// job register, so a second job can be accepted while one is running.
module snax_simbacore_ctrl_shell #(
  parameter int unsigned RegRWCount   = 7,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned ModeWidth    = 12,
  parameter int unsigned NumOutCh     = 4,
  parameter int unsigned RegROCount   = 3 + NumOutCh
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
  input  logic                               csr_reg_set_valid_i,
  output logic                               csr_reg_set_ready_o,
  output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
  output logic                               cfg_valid_o,
  input  logic                               cfg_ready_i,
  output logic [ModeWidth-1:0]               cfg_mode_o,
  output logic [5*RegDataWidth-1:0]          cfg_dims_o,
  input  logic                               acc_busy_i,
  input  logic [NumOutCh-1:0]                out_valid_i,
  input  logic [NumOutCh-1:0]                out_ready_i
);

  localparam int unsigned W    = RegDataWidth;
  localparam int unsigned PopW = $clog2(NumOutCh + 1);
  localparam logic [W-1:0] CntMax = {W{1'b1}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ModeWidth-1:0] mode_q;
  logic [5*W-1:0]       dims_q;
  logic [W-1:0]         exp_q;
  logic [W-1:0]         cycle_q;
  logic [W-1:0]         total_q;
  logic [W-1:0]         ch_cnt_q [NumOutCh];

  logic [ModeWidth-1:0] csr_mode, job_mode;
  logic [5*W-1:0]       csr_dims, job_dims;
  logic [W-1:0]         csr_exp, job_exp;

  logic                 job_hs;
  logic                 run_done;
  logic                 load_job;
  logic                 load_shadow_job;
  logic                 queued;

  logic [NumOutCh-1:0]  fire;
  logic [PopW-1:0]      beat_pop;
  logic [W:0]           total_sum;
  logic [W-1:0]         total_next;

  logic                 unused_csr;

  assign csr_mode   = csr_reg_set_i[ModeWidth-1:0];
  assign csr_dims   = csr_reg_set_i[6*W-1:W];
  assign csr_exp    = csr_reg_set_i[7*W-1:6*W];
  // Upper mode bits and any extra CSR words carry no meaning here.
  assign unused_csr = ^csr_reg_set_i;

  assign job_hs   = csr_reg_set_valid_i && csr_reg_set_ready_o;
  assign run_done = (state_q == StRun) && !acc_busy_i && (total_q >= exp_q);

`ifdef SNAX_SIMBACORE_CFG_QUEUE_EN
  logic                 sh_valid_q;
  logic [ModeWidth-1:0] sh_mode_q;
  logic [5*W-1:0]       sh_dims_q;
  logic [W-1:0]         sh_exp_q;

  assign queued              = sh_valid_q;
  assign csr_reg_set_ready_o = (state_q == StIdle) || !sh_valid_q;
  assign job_mode            = load_shadow_job ? sh_mode_q : csr_mode;
  assign job_dims            = load_shadow_job ? sh_dims_q : csr_dims;
  assign job_exp             = load_shadow_job ? sh_exp_q  : csr_exp;

  // Shadow slot: filled by a job accepted while busy, freed when it is promoted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_valid_q <= 1'b0;
      sh_mode_q  <= '0;
      sh_dims_q  <= '0;
      sh_exp_q   <= '0;
    end else if (load_shadow_job) begin
      sh_valid_q <= 1'b0;
    end else if (job_hs && !load_job) begin
      sh_valid_q <= 1'b1;
      sh_mode_q  <= csr_mode;
      sh_dims_q  <= csr_dims;
      sh_exp_q   <= csr_exp;
    end
  end
`else
  logic unused_shadow;

  assign queued              = 1'b0;
  assign csr_reg_set_ready_o = (state_q == StIdle);
  assign job_mode            = csr_mode;
  assign job_dims            = csr_dims;
  assign job_exp             = csr_exp;
  assign unused_shadow       = load_shadow_job;
`endif

  // Next-state logic; load_job marks every cycle a job enters the active registers.
  always_comb begin
    state_d         = state_q;
    load_job        = 1'b0;
    load_shadow_job = 1'b0;
    case (state_q)
      StIdle: begin
        if (job_hs) begin
          state_d  = StLaunch;
          load_job = 1'b1;
        end
      end
      StLaunch: begin
        if (cfg_ready_i) state_d = StRun;
      end
      StRun: begin
        if (run_done) begin
          if (queued) begin
            state_d         = StLaunch;
            load_job        = 1'b1;
            load_shadow_job = 1'b1;
          end else if (job_hs) begin
            // A job offered in the exit cycle launches directly instead of being dropped.
            state_d  = StLaunch;
            load_job = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and active job registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= '0;
      dims_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_job) begin
        mode_q <= job_mode;
        dims_q <= job_dims;
        exp_q  <= job_exp;
      end
    end
  end

  // Beat fires this cycle and the saturating running total.
  always_comb begin
    fire     = out_valid_i & out_ready_i;
    beat_pop = '0;
    for (int i = 0; i < NumOutCh; i++) begin
      beat_pop = beat_pop + PopW'(fire[i]);
    end
    total_sum  = {1'b0, total_q} + (W + 1)'(beat_pop);
    total_next = total_sum[W] ? CntMax : total_sum[W-1:0];
  end

  // Counters: cleared on job load, advance only while a job is active, hold in idle.
  always_ff @(posedge clk_i) begin
    if (rst_i || load_job) begin
      cycle_q <= '0;
      total_q <= '0;
      for (int i = 0; i < NumOutCh; i++) ch_cnt_q[i] <= '0;
    end else if (state_q != StIdle) begin
      if (cycle_q != CntMax) cycle_q <= cycle_q + W'(1);
      total_q <= total_next;
      for (int i = 0; i < NumOutCh; i++) begin
        if (fire[i] && (ch_cnt_q[i] != CntMax)) ch_cnt_q[i] <= ch_cnt_q[i] + W'(1);
      end
    end
  end

  // RO CSR image: status, cycles, total beats, per-channel beats.
  always_comb begin
    csr_reg_ro_set_o          = '0;
    csr_reg_ro_set_o[0 +: W]  = {{(W - 2){1'b0}}, queued, (state_q != StIdle)};
    csr_reg_ro_set_o[W +: W]  = cycle_q;
    csr_reg_ro_set_o[2*W +: W] = total_q;
    for (int i = 0; i < NumOutCh; i++) begin
      csr_reg_ro_set_o[(3 + i)*W +: W] = ch_cnt_q[i];
    end
  end

  assign cfg_valid_o = (state_q == StLaunch);
  assign cfg_mode_o  = mode_q;
  assign cfg_dims_o  = dims_q;

endmodule

// File: tb/tb_snax_simbacore_ctrl_shell.sv
// Directed self-checking bench for snax_simbacore_ctrl_shell.
// The queue scenario follows SNAX_SIMBACORE_CFG_QUEUE_EN like the design does.
module tb_snax_simbacore_ctrl_shell;

  localparam int W   = 32;
  localparam int NCh = 4;
  localparam int ROC = 3 + NCh;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    csr_w [7];
  logic [7*W-1:0] csr_vec;
  logic           job_valid = 1'b0;
  logic           job_ready;
  logic [ROC*W-1:0] ro_set;
  logic           cfg_valid;
  logic           cfg_ready = 1'b0;
  logic [11:0]    cfg_mode;
  logic [5*W-1:0] cfg_dims;
  logic           acc_busy = 1'b0;
  logic [NCh-1:0] out_valid = '0;
  logic [NCh-1:0] out_ready = '0;

  int total = 0;
  int bad   = 0;

  assign csr_vec = {csr_w[6], csr_w[5], csr_w[4], csr_w[3], csr_w[2], csr_w[1], csr_w[0]};

  always #5 clk = ~clk;

  snax_simbacore_ctrl_shell dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .csr_reg_set_i       (csr_vec),
    .csr_reg_set_valid_i (job_valid),
    .csr_reg_set_ready_o (job_ready),
    .csr_reg_ro_set_o    (ro_set),
    .cfg_valid_o         (cfg_valid),
    .cfg_ready_i         (cfg_ready),
    .cfg_mode_o          (cfg_mode),
    .cfg_dims_o          (cfg_dims),
    .acc_busy_i          (acc_busy),
    .out_valid_i         (out_valid),
    .out_ready_i         (out_ready)
  );

  function automatic logic [31:0] ro(input int k);
    return ro_set[k*W +: W];
  endfunction

  // Loads the CSR words; upper mode bits are junk that must not reach cfg_mode.
  task automatic set_job(input logic [11:0] mode, input logic [31:0] e, input logic [31:0] base);
    csr_w[0] = 32'hABCD_E000 | {20'd0, mode};
    for (int k = 1; k <= 5; k++) csr_w[k] = base + 32'(k);
    csr_w[6] = e;
  endtask

  function automatic logic [5*W-1:0] dims_of(input logic [31:0] base);
    return {base + 32'd5, base + 32'd4, base + 32'd3, base + 32'd2, base + 32'd1};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_cfg_valid: got %b want 0", cfg_valid); end
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", job_ready); end
    total++; if (ro_set !== '0) begin bad++; $display("FAIL reset_ro: got %h want 0", ro_set); end
    total++; if (cfg_mode !== 12'd0) begin bad++; $display("FAIL reset_mode: got %h want 0", cfg_mode); end
    total++; if (cfg_dims !== '0) begin bad++; $display("FAIL reset_dims: got %h want 0", cfg_dims); end
  endtask

  task automatic test_single();
    set_job(12'h005, 32'd8, 32'h100);
    cfg_ready = 1'b0;
    acc_busy  = 1'b1;
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL single_stall_valid%0d: got %b want 1", k, cfg_valid); end
      total++; if (cfg_dims !== dims_of(32'h100)) begin bad++; $display("FAIL single_stall_dims%0d: got %h want %h", k, cfg_dims, dims_of(32'h100)); end
      total++; if (cfg_mode !== 12'h005) begin bad++; $display("FAIL single_mode%0d: got %h want 005", k, cfg_mode); end
      cyc();
    end
    cfg_ready = 1'b1;
    #1;
    total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL single_valid_4th: got %b want 1", cfg_valid); end
    cyc();
    cfg_ready = 1'b0;
    #1;
    total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop: got %b want 0", cfg_valid); end
    total++; if (ro(1) !== 32'd4) begin bad++; $display("FAIL single_launch_cycles: got %0d want 4", ro(1)); end
    // One stalled beat (valid without ready) then eight fires on ch0.
    out_valid = 4'b0001;
    out_ready = 4'b0000;
    cyc();
    out_ready = 4'b0001;
    repeat (8) cyc();
    out_valid = 4'b0000;
    out_ready = 4'b0000;
    #1;
    total++; if (ro(2) !== 32'd8) begin bad++; $display("FAIL single_beats_run: got %0d want 8", ro(2)); end
    cyc();
    total++; if (ro(0) !== 32'd1) begin bad++; $display("FAIL single_busy_hold: got %h want 1", ro(0)); end
    acc_busy = 1'b0;
    cyc();
    total++; if (ro(0) !== 32'd0) begin bad++; $display("FAIL single_status_idle: got %h want 0", ro(0)); end
    total++; if (ro(2) !== 32'd8) begin bad++; $display("FAIL single_total: got %0d want 8", ro(2)); end
    total++; if (ro(3) !== 32'd8) begin bad++; $display("FAIL single_ch0: got %0d want 8", ro(3)); end
    total++; if (ro(4) !== 32'd0) begin bad++; $display("FAIL single_ch1: got %0d want 0", ro(4)); end
    total++; if (ro(1) !== 32'd15) begin bad++; $display("FAIL single_cycles: got %0d want 15", ro(1)); end
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL single_ready_idle: got %b want 1", job_ready); end
    cyc();
    total++; if (ro(2) !== 32'd8) begin bad++; $display("FAIL single_hold_idle: got %0d want 8", ro(2)); end
  endtask

  task automatic test_multi();
    set_job(12'h00C, 32'd16, 32'h200);
    cfg_ready = 1'b1;
    acc_busy  = 1'b1;
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    total++; if (ro(2) !== 32'd0) begin bad++; $display("FAIL multi_clear: got %0d want 0", ro(2)); end
    cyc();
    out_valid = 4'hF;
    out_ready = 4'hF;
    repeat (4) cyc();
    out_valid = 4'h0;
    out_ready = 4'h0;
    #1;
    total++; if (ro(2) !== 32'd16) begin bad++; $display("FAIL multi_total_run: got %0d want 16", ro(2)); end
    cyc();
    total++; if (ro(0) !== 32'd1) begin bad++; $display("FAIL multi_wait_busy: got %h want 1", ro(0)); end
    acc_busy = 1'b0;
    cyc();
    total++; if (ro(0) !== 32'd0) begin bad++; $display("FAIL multi_status_idle: got %h want 0", ro(0)); end
    total++; if (ro(2) !== 32'd16) begin bad++; $display("FAIL multi_total: got %0d want 16", ro(2)); end
    for (int i = 0; i < NCh; i++) begin
      total++; if (ro(3 + i) !== 32'd4) begin bad++; $display("FAIL multi_ch%0d: got %0d want 4", i, ro(3 + i)); end
    end
    cfg_ready = 1'b0;
  endtask

  task automatic test_early_idle();
    set_job(12'h0E1, 32'd10, 32'h300);
    cfg_ready = 1'b1;
    acc_busy  = 1'b0;
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    cyc();
    out_valid = 4'b0100;
    out_ready = 4'b0100;
    repeat (5) cyc();
    out_valid = 4'b0000;
    cyc();
    cyc();
    total++; if (ro(0) !== 32'd1) begin bad++; $display("FAIL early_stay_run: got %h want 1", ro(0)); end
    total++; if (ro(2) !== 32'd5) begin bad++; $display("FAIL early_total5: got %0d want 5", ro(2)); end
    out_valid = 4'b0100;
    repeat (4) cyc();
    total++; if (ro(0) !== 32'd1) begin bad++; $display("FAIL early_beat9_run: got %h want 1", ro(0)); end
    cyc();
    out_valid = 4'b0000;
    out_ready = 4'b0000;
    #1;
    total++; if (ro(2) !== 32'd10) begin bad++; $display("FAIL early_total10: got %0d want 10", ro(2)); end
    cyc();
    total++; if (ro(0) !== 32'd0) begin bad++; $display("FAIL early_done: got %h want 0", ro(0)); end
    total++; if (ro(5) !== 32'd10) begin bad++; $display("FAIL early_ch2: got %0d want 10", ro(5)); end
    cfg_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_job(12'h0F0, 32'd100, 32'h400);
    cfg_ready = 1'b1;
    acc_busy  = 1'b1;
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    cyc();
    out_valid = 4'b0010;
    out_ready = 4'b0010;
    repeat (3) cyc();
    out_valid = 4'b0000;
    out_ready = 4'b0000;
    #1;
    total++; if (ro(4) !== 32'd3) begin bad++; $display("FAIL rstmid_ch1: got %0d want 3", ro(4)); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL rstmid_cfg_valid: got %b want 0", cfg_valid); end
    total++; if (ro_set !== '0) begin bad++; $display("FAIL rstmid_ro: got %h want 0", ro_set); end
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", job_ready); end
    total++; if (cfg_mode !== 12'd0) begin bad++; $display("FAIL rstmid_mode: got %h want 0", cfg_mode); end
    cfg_ready = 1'b0;
    acc_busy  = 1'b0;
  endtask

`ifdef SNAX_SIMBACORE_CFG_QUEUE_EN
  task automatic test_queue();
    set_job(12'h0A1, 32'd2, 32'h500);
    cfg_ready = 1'b1;
    acc_busy  = 1'b1;
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    cyc();
    set_job(12'h0B2, 32'd1, 32'h600);
    job_valid = 1'b1;
    #1;
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL queue_ready_run: got %b want 1", job_ready); end
    cyc();
    job_valid = 1'b0;
    #1;
    total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL queue_ready_full: got %b want 0", job_ready); end
    total++; if (ro(0) !== 32'd3) begin bad++; $display("FAIL queue_status: got %h want 3", ro(0)); end
    total++; if (cfg_mode !== 12'h0A1) begin bad++; $display("FAIL queue_active_mode: got %h want 0a1", cfg_mode); end
    out_valid = 4'b0001;
    out_ready = 4'b0001;
    repeat (2) cyc();
    out_valid = 4'b0000;
    out_ready = 4'b0000;
    acc_busy  = 1'b0;
    cyc();
    total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL queue_launch: got %b want 1", cfg_valid); end
    total++; if (cfg_mode !== 12'h0B2) begin bad++; $display("FAIL queue_mode2: got %h want 0b2", cfg_mode); end
    total++; if (cfg_dims !== dims_of(32'h600)) begin bad++; $display("FAIL queue_dims2: got %h want %h", cfg_dims, dims_of(32'h600)); end
    total++; if (ro(2) !== 32'd0) begin bad++; $display("FAIL queue_cleared: got %0d want 0", ro(2)); end
    total++; if (ro(0) !== 32'd1) begin bad++; $display("FAIL queue_status2: got %h want 1", ro(0)); end
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL queue_ready_free: got %b want 1", job_ready); end
    cyc();
    out_valid = 4'b0001;
    out_ready = 4'b0001;
    cyc();
    out_valid = 4'b0000;
    out_ready = 4'b0000;
    cyc();
    total++; if (ro(0) !== 32'd0) begin bad++; $display("FAIL queue_done: got %h want 0", ro(0)); end
    total++; if (ro(2) !== 32'd1) begin bad++; $display("FAIL queue_total2: got %0d want 1", ro(2)); end
    cfg_ready = 1'b0;
  endtask
`else
  task automatic test_queue();
    set_job(12'h0A1, 32'd2, 32'h500);
    cfg_ready = 1'b0;
    acc_busy  = 1'b1;
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    #1;
    total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL noq_ready_launch: got %b want 0", job_ready); end
    cfg_ready = 1'b1;
    cyc();
    cfg_ready = 1'b0;
    set_job(12'h0B2, 32'd1, 32'h600);
    job_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL noq_ready_run%0d: got %b want 0", k, job_ready); end
      total++; if (ro(0) !== 32'd1) begin bad++; $display("FAIL noq_status%0d: got %h want 1", k, ro(0)); end
      cyc();
    end
    job_valid = 1'b0;
    out_valid = 4'b0001;
    out_ready = 4'b0001;
    repeat (2) cyc();
    out_valid = 4'b0000;
    out_ready = 4'b0000;
    acc_busy  = 1'b0;
    cyc();
    total++; if (ro(0) !== 32'd0) begin bad++; $display("FAIL noq_done: got %h want 0", ro(0)); end
    total++; if (cfg_mode !== 12'h0A1) begin bad++; $display("FAIL noq_mode_kept: got %h want 0a1", cfg_mode); end
    total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL noq_no_launch: got %b want 0", cfg_valid); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 7; k++) csr_w[k] = '0;
    test_reset();
    test_single();
    test_multi();
    test_early_idle();
    test_reset_mid();
    test_queue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
